stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM and timebase that sequences the BCD stopwatch counter datapath.
//  Synchronises and edge-detects the start/stop and clear buttons, and generates the
//  counter clear/preset, count-enable tick and direction.
//  Detects terminal count and stops there. Sits between board buttons and the 4-digit BCD counter/display mux.
// PARAMETERS
//  TICK_DIV     1_000_000  c_clk cycles per count tick (100 MHz -> 100 Hz); >= 2
//  SYNC_STAGES  2          flops in each button synchroniser; >= 2
// PORTS
//  c_clk      in   1   system clock; all logic on rising edge
//  C_clr      in   1   reset, asynchronous, active-high
//  start_btn  in   1   raw async start/stop button, active-high
//  clear_btn  in   1   raw async clear button, active-high
//  lap_btn    in   1   raw async lap button; used only with LAP_HOLD_EN
//  sel        in   2   mode: 00 up from 0, 01 up from preset, 10 down from 9999, 11 down from preset
//  load       in   8   BCD preset, two upper digits {d3,d2}
//  count      in   16  current 4-digit BCD counter value
//  cnt_clr    out  1   counter load-preset strobe (level)
//  preset     out  16  BCD value counter loads while cnt_clr=1
//  cnt_en     out  1   one-cycle count tick
//  dir        out  1   0 = up, 1 = down
//  running    out  1   1 in RUN
//  done       out  1   1 in DONE
//  disp       out  16  value for display mux
// BEHAVIOUR
//  Reset (C_clr=1): state=IDLE; prescaler=0; sync/edge flops=0; mode_q=00; lap hold cleared.
//   Outputs: cnt_clr=1, cnt_en=0, dir=0, running=0, done=0.
//  Buttons: SYNC_STAGES-flop synchroniser, then rising-edge detect.
//   Input rise -> state change on the (SYNC_STAGES+1)th c_clk edge.
//   A held button gives one event only.
//  preset: 00 -> 16'h0000; 10 -> 16'h9999; 01/11 -> {load[7:4],load[3:0],8'h00}.
//   Any load nibble > 9 is clamped to 9.
//  mode_q = sel, sampled every cycle in IDLE and frozen outside IDLE; dir = mode_q[1].
//   sel changes during RUN/PAUSE/DONE are ignored until the next IDLE.
//  term = (dir==0 && count==16'h9999) || (dir==1 && count==16'h0000).
//  States (2-bit), priority clear_edge > term > start_edge:
//   IDLE : cnt_clr=1; prescaler held at 0.
//          start_edge -> RUN; if term already true -> DONE instead.
//   RUN  : running=1; prescaler counts 0..TICK_DIV-1 and wraps.
//          cnt_en=1 only in the cycle prescaler==TICK_DIV-1 && !term.
//          term -> DONE; start_edge -> PAUSE.
//   PAUSE: prescaler held, keeping phase; cnt_en=0. start_edge -> RUN.
//   DONE : done=1; cnt_en=0; start_edge ignored.
//  clear_edge in any state -> IDLE; prescaler zeroed on entry.
//  Counter never wraps: cnt_en is suppressed at term, so 9999 and 0000 are sticky.
//  C_clr mid-operation forces reset values immediately, with no clock needed.
//  cnt_en, running, done and cnt_clr are decoded from registered state/prescaler (glitch-free).
// CONFIGURATION
//  LAP_HOLD_EN defined:
//   In RUN or PAUSE, lap_edge toggles hold. hold=1 latches disp<=count and freezes it.
//   hold=0 makes disp follow count. Counting is unaffected.
//   hold clears on clear_edge or reset; hold is kept on entering DONE.
//  LAP_HOLD_EN undefined: disp = count combinationally; lap_btn is unused (port stays).
// TESTING
//  All tests use TICK_DIV=4, SYNC_STAGES=2; a behavioural BCD counter model is driven by cnt_clr/cnt_en/dir.
//  1. Reset, sel=00, pulse start_btn -> running=1 on the 3rd edge; cnt_en every 4th cycle; count 0000,0001,0002...
//  2. Start, then press start again mid-period (prescaler=2), then resume -> no cnt_en while paused;
//     first cnt_en exactly 1 cycle after resume (phase kept).
//  3. sel=01, load=8'h3A -> preset=16'h3900 and count=3900 in IDLE.
//     Run to 9999 -> done=1, cnt_en=0; start ignored; clear -> IDLE, count=3900.
//  4. sel=11, load=8'h00, start -> DONE directly without any cnt_en.
//     sel=10, start: count 9999->9998; at 0000 done=1 and count holds at 0000.
//  5. start_btn and clear_btn rise in the same cycle during RUN -> IDLE, cnt_clr=1, running=0.
//     Assert C_clr mid-RUN -> all outputs at reset values within the same cycle.
//  6. LAP_HOLD_EN: lap at count 0042 -> disp holds 0042 while count advances; second lap -> disp tracks count.
//     Without the macro, lap_btn has no effect.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button synchronisers, run/pause/done sequencing and count-tick
// timebase for a 4-digit BCD stopwatch counter.
// Optional feature macro: LAP_HOLD_EN (lap button freezes the display value).
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV    = 1_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        c_clk,
  input  logic        C_clr,
  input  logic        start_btn,
  input  logic        clear_btn,
  input  logic        lap_btn,
  input  logic [1:0]  sel,
  input  logic [7:0]  load,
  input  logic [15:0] count,
  output logic        cnt_clr,
  output logic [15:0] preset,
  output logic        cnt_en,
  output logic        dir,
  output logic        running,
  output logic        done,
  output logic [15:0] disp
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
`ifdef LAP_HOLD_EN
  localparam int unsigned NB = 3;
`else
  localparam int unsigned NB = 2;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [PW-1:0]                 presc_q, presc_d;
  logic [1:0]                    mode_q, mode_d;
  logic [SYNC_STAGES-1:0][NB-1:0] sync_q, sync_d;
  logic [NB-1:0]                 prev_q, prev_d;
  logic [NB-1:0]                 btn_raw;
  logic [NB-1:0]                 btn_edge;
  logic                          start_edge;
  logic                          clear_edge;
  logic                          term;

`ifdef LAP_HOLD_EN
  assign btn_raw = {lap_btn, clear_btn, start_btn};
`else
  assign btn_raw = {clear_btn, start_btn};
`endif

  // Clamp a BCD nibble to a legal digit.
  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Synchroniser shift and rising-edge detect on the last stage.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], btn_raw};
    prev_d   = sync_q[SYNC_STAGES-1];
    btn_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  assign start_edge = btn_edge[0];
  assign clear_edge = btn_edge[1];

  assign dir  = mode_q[1];
  assign term = dir ? (count == 16'h0000) : (count == 16'h9999);

  // Preset value selected by the frozen mode.
  always_comb begin
    preset = 16'h0000;
    case (mode_q)
      2'b00:   preset = 16'h0000;
      2'b10:   preset = 16'h9999;
      default: preset = {clamp9(load[7:4]), clamp9(load[3:0]), 8'h00};
    endcase
  end

  // Next-state, prescaler and mode capture.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    if (state_q == S_IDLE) mode_d = sel;
    if (clear_edge) begin
      state_d = S_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          if (start_edge) state_d = term ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (term)            state_d = S_DONE;
          else if (start_edge) state_d = S_PAUSE;
          else presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
        end
        S_PAUSE: begin
          if (start_edge) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge c_clk or posedge C_clr) begin
    if (C_clr) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      mode_q  <= 2'b00;
      sync_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
    end
  end

  assign cnt_clr = (state_q == S_IDLE);
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign cnt_en  = (state_q == S_RUN) && (presc_q == PMAX) && !term;

`ifdef LAP_HOLD_EN
  logic        hold_q, hold_d;
  logic [15:0] lap_q, lap_d;

  // Lap toggle: capture count on entering hold, release on second press.
  always_comb begin
    hold_d = hold_q;
    lap_d  = lap_q;
    if (clear_edge) begin
      hold_d = 1'b0;
    end else if (((state_q == S_RUN) || (state_q == S_PAUSE)) && btn_edge[2]) begin
      hold_d = ~hold_q;
      if (!hold_q) lap_d = count;
    end
  end

  // Lap hold registers.
  always_ff @(posedge c_clk or posedge C_clr) begin
    if (C_clr) begin
      hold_q <= 1'b0;
      lap_q  <= 16'h0000;
    end else begin
      hold_q <= hold_d;
      lap_q  <= lap_d;
    end
  end

  assign disp = hold_q ? lap_q : count;
`else
  logic unused_lap_c;
  assign unused_lap_c = lap_btn;
  assign disp = count;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: behavioural controller model plus a BCD counter
// environment driven by the DUT strobes; outputs compared every cycle.
module tb_stopwatch_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned SS = 2;

  logic        c_clk = 1'b0;
  logic        C_clr;
  logic        start_btn, clear_btn, lap_btn;
  logic [1:0]  sel;
  logic [7:0]  load;
  logic [15:0] count;
  logic        cnt_clr, cnt_en, dir, running, done;
  logic [15:0] preset, disp;

  always #5 c_clk = ~c_clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .SYNC_STAGES(SS)) dut (
    .c_clk(c_clk), .C_clr(C_clr), .start_btn(start_btn), .clear_btn(clear_btn),
    .lap_btn(lap_btn), .sel(sel), .load(load), .count(count), .cnt_clr(cnt_clr),
    .preset(preset), .cnt_en(cnt_en), .dir(dir), .running(running), .done(done),
    .disp(disp)
  );

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  mst_t        m_st;
  int          m_run_cycles;
  logic [1:0]  m_mode;
  bit          m_hold;
  logic [15:0] m_lap;
  logic [SS+1:0] h_s, h_c, h_l;
  logic [15:0] count_nx;

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] dig(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic [15:0] exp_preset(input logic [1:0] m, input logic [7:0] l);
    if (m == 2'b00) return 16'h0000;
    if (m == 2'b10) return 16'h9999;
    return {dig(l[7:4]), dig(l[3:0]), 8'h00};
  endfunction

  function automatic bit m_term();
    return m_mode[1] ? (count == 16'h0000) : (count == 16'h9999);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_st = M_IDLE;
    m_run_cycles = 0;
    m_mode = 2'b00;
    m_hold = 1'b0;
    m_lap = 16'h0000;
    h_s = '0;
    h_c = '0;
    h_l = '0;
  endtask

  // Compare every output against what the model says this cycle should show.
  task automatic check_all();
    logic [15:0] exp_disp;
    exp_disp = count;
`ifdef LAP_HOLD_EN
    if (m_hold) exp_disp = m_lap;
`endif
    chk("cnt_clr", 16'(cnt_clr), 16'(m_st == M_IDLE));
    chk("running", 16'(running), 16'(m_st == M_RUN));
    chk("done", 16'(done), 16'(m_st == M_DONE));
    chk("dir", 16'(dir), 16'(m_mode[1]));
    chk("preset", preset, exp_preset(m_mode, load));
    chk("cnt_en", 16'(cnt_en),
        16'(m_st == M_RUN && (m_run_cycles % TD) == TD - 1 && !m_term()));
    chk("disp", disp, exp_disp);
  endtask

  // Advance the model across the next rising edge using the inputs now applied.
  task automatic model_step();
    bit se, ce, le, t, was_idle;
    int v;
    h_s = {h_s[SS:0], start_btn};
    h_c = {h_c[SS:0], clear_btn};
    h_l = {h_l[SS:0], lap_btn};
    se = h_s[SS] & ~h_s[SS+1];
    ce = h_c[SS] & ~h_c[SS+1];
    le = h_l[SS] & ~h_l[SS+1];
    t = m_term();
    was_idle = (m_st == M_IDLE);
    v = bcd2int(count);
    if (cnt_clr)     count_nx = preset;
    else if (cnt_en) count_nx = int2bcd(dir ? (v + 9999) % 10000 : (v + 1) % 10000);
    else             count_nx = count;
`ifdef LAP_HOLD_EN
    if (ce) m_hold = 1'b0;
    else if ((m_st == M_RUN || m_st == M_PAUSE) && le) begin
      if (!m_hold) m_lap = count;
      m_hold = !m_hold;
    end
`else
    if (le) m_hold = 1'b0;
`endif
    if (ce) begin
      m_st = M_IDLE;
      m_run_cycles = 0;
    end else if (m_st == M_IDLE) begin
      m_run_cycles = 0;
      if (se) m_st = t ? M_DONE : M_RUN;
    end else if (m_st == M_RUN) begin
      if (t)       m_st = M_DONE;
      else if (se) m_st = M_PAUSE;
      else         m_run_cycles++;
    end else if (m_st == M_PAUSE) begin
      if (se) m_st = M_RUN;
    end
    if (was_idle) m_mode = sel;
  endtask

  task automatic tick();
    model_step();
    @(posedge c_clk);
    @(negedge c_clk);
    count = count_nx;
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
  endtask

  task automatic press_clear();
    clear_btn = 1'b1;
    tick();
    clear_btn = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_done", 16'(done), 16'd1);
  endtask

  initial begin
    C_clr = 1'b1;
    start_btn = 1'b0;
    clear_btn = 1'b0;
    lap_btn = 1'b0;
    sel = 2'b00;
    load = 8'h00;
    count = 16'h0000;
    reset_model();
    #1;
    chk("rst_cnt_clr", 16'(cnt_clr), 16'd1);
    chk("rst_cnt_en", 16'(cnt_en), 16'd0);
    chk("rst_running", 16'(running), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_dir", 16'(dir), 16'd0);
    repeat (2) @(negedge c_clk);
    #1;
    C_clr = 1'b0;
    ticks(3);
    chk("idle_count", count, 16'h0000);

    // Start from zero: running on third edge, one tick every four cycles.
    press_start();
    tick();
    chk("t1_run_e2", 16'(running), 16'd0);
    tick();
    chk("t1_run_e3", 16'(running), 16'd1);
    ticks(4);
    chk("t1_cnt1", count, 16'h0001);
    ticks(4);
    chk("t1_cnt2", count, 16'h0002);

    // Pause mid-period, phase is kept across the pause.
    press_start();
    ticks(2);
    chk("t2_paused", 16'(running), 16'd0);
    chk("t2_cnt_hold", count, 16'h0002);
    ticks(6);
    chk("t2_cnt_still", count, 16'h0002);
    press_start();
    ticks(2);
    chk("t2_resumed", 16'(running), 16'd1);
    chk("t2_no_tick_yet", 16'(cnt_en), 16'd0);
    tick();
    chk("t2_tick", 16'(cnt_en), 16'd1);
    tick();
    chk("t2_cnt3", count, 16'h0003);

    // Start and clear together: clear wins.
    start_btn = 1'b1;
    clear_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    clear_btn = 1'b0;
    ticks(2);
    chk("t5_running", 16'(running), 16'd0);
    chk("t5_cnt_clr", 16'(cnt_clr), 16'd1);

    // Up from clamped preset, stop at 9999.
    sel = 2'b01;
    load = 8'h3A;
    ticks(3);
    chk("t3_preset", preset, 16'h3900);
    chk("t3_count", count, 16'h3900);
    load = 8'h99;
    ticks(2);
    chk("t3_count99", count, 16'h9900);
    press_start();
    wait_done(1000);
    chk("t3_top", count, 16'h9999);
    ticks(4);
    chk("t3_sticky", count, 16'h9999);
    press_start();
    ticks(5);
    chk("t3_start_ignored", 16'(done), 16'd1);
    press_clear();
    load = 8'h3A;
    ticks(4);
    chk("t3_cleared", count, 16'h3900);
    chk("t3_not_done", 16'(done), 16'd0);

    // Down from 0000 preset: straight to DONE.
    sel = 2'b11;
    load = 8'h00;
    ticks(3);
    press_start();
    ticks(3);
    chk("t4_done_direct", 16'(done), 16'd1);
    chk("t4_zero", count, 16'h0000);
    press_clear();
    sel = 2'b10;
    ticks(4);
    chk("t4_9999", count, 16'h9999);
    press_start();
    ticks(2 + 4);
    chk("t4_9998", count, 16'h9998);
    press_clear();
    sel = 2'b11;
    load = 8'h01;
    ticks(4);
    chk("t4_0100", count, 16'h0100);
    press_start();
    wait_done(1000);
    chk("t4_bottom", count, 16'h0000);
    ticks(4);
    chk("t4_sticky", count, 16'h0000);

    // Asynchronous reset in the middle of a run.
    press_clear();
    sel = 2'b00;
    ticks(4);
    press_start();
    ticks(10);
    C_clr = 1'b1;
    #1;
    chk("t5_ar_cnt_clr", 16'(cnt_clr), 16'd1);
    chk("t5_ar_cnt_en", 16'(cnt_en), 16'd0);
    chk("t5_ar_running", 16'(running), 16'd0);
    chk("t5_ar_done", 16'(done), 16'd0);
    chk("t5_ar_dir", 16'(dir), 16'd0);
    reset_model();
    @(posedge c_clk);
    @(negedge c_clk);
    count = 16'h0000;
    C_clr = 1'b0;
    #1;
    check_all();

    // Randomised button traffic, mode/preset changes and lap presses.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 90) == 0) clear_btn = ~clear_btn;
      if ($urandom_range(0, 20) == 0) lap_btn = ~lap_btn;
      if ($urandom_range(0, 40) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) load = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
